// File: rtl/param_traffic_light_controller_pkg.sv
// Shared definitions for the parameterised intersection controller:
// state encodings, lamp bit positions, synchroniser lane indices and the
// small BCD helpers used by the countdown timer.
package param_traffic_light_controller_pkg;

    // Controller states (3-bit, kept as plain constants for legacy tools)
    localparam logic [2:0] ST_HG    = 3'd0;  // highway green
    localparam logic [2:0] ST_HY    = 3'd1;  // highway yellow
    localparam logic [2:0] ST_SG    = 3'd2;  // street green
    localparam logic [2:0] ST_SY    = 3'd3;  // street yellow
    localparam logic [2:0] ST_PED   = 3'd4;  // all-red pedestrian walk
    localparam logic [2:0] ST_FLASH = 3'd5;  // night flashing

    // Bit positions inside the internal lamp vector
    localparam int LAMP_RED_HW    = 0;
    localparam int LAMP_YELLOW_HW = 1;
    localparam int LAMP_GREEN_HW  = 2;
    localparam int LAMP_RED_ST    = 3;
    localparam int LAMP_YELLOW_ST = 4;
    localparam int LAMP_GREEN_ST  = 5;
    localparam int LAMP_WALK      = 6;
    localparam int NUM_LAMPS      = 7;

    // Lanes of the shared input synchroniser
    localparam int SYNC_CAR   = 0;
    localparam int SYNC_PED   = 1;
    localparam int SYNC_NIGHT = 2;
    localparam int SYNC_WIDTH = 3;

    // Two-digit BCD countdown value
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    localparam bcd_t BCD_ZERO = '0;

    // Convert a 0..99 constant into its BCD digit pair
    function automatic bcd_t bcd_load(input int value);
        bcd_t r;
        r.tens = 4'((value / 10) % 10);
        r.ones = 4'(value % 10);
        return r;
    endfunction

    // Decrement by one with decimal borrow from the tens digit
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = v.tens - 4'd1;
        end else begin
            r.ones = v.ones - 4'd1;
        end
        return r;
    endfunction

    // True when the value is exactly 01
    function automatic logic bcd_is_one(input bcd_t v);
        return (v.tens == 4'd0) && (v.ones == 4'd1);
    endfunction

    // True when the value is 02 or more
    function automatic logic bcd_gt_one(input bcd_t v);
        return (v.tens != 4'd0) || (v.ones > 4'd1);
    endfunction

endpackage

// File: rtl/param_traffic_light_controller_input_synchroniser.sv
// Multi-bit input synchroniser: each lane is an independent chain of
// STAGES flops, so a lane's output lags its input by STAGES clock cycles.
// Lanes are not coherent with each other; only use it for unrelated bits.
module param_traffic_light_controller_input_synchroniser #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_bits,
    output logic [WIDTH-1:0] sync_bits
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic [STAGES-1:0] chain_reg;

            // Shift the raw input through the lane's flop chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[STAGES-2:0], async_bits[gi]};
                end
            end

            assign sync_bits[gi] = chain_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/param_traffic_light_controller.sv
// Highway/street intersection controller with pedestrian walk phase and
// night flashing mode. A prescaler produces a one-cycle tick per second;
// the countdown is kept directly in BCD so the display needs no divider.
// Transitions happen only on a tick, normally when the countdown reads 01.
module param_traffic_light_controller
    import param_traffic_light_controller_pkg::*;
#(
    parameter int CLK_DIV     = 50000000,
    parameter int T_LONG      = 25,
    parameter int T_SHORT     = 5,
    parameter int T_PED       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_async,
    input  logic       ped_async,
    input  logic       night_async,
    output logic       red_highway,
    output logic       yellow_highway,
    output logic       green_highway,
    output logic       red_street,
    output logic       yellow_street,
    output logic       green_street,
    output logic       walk,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones
);

    localparam int                 PRESC_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    localparam bcd_t LOAD_LONG  = bcd_load(T_LONG);
    localparam bcd_t LOAD_SHORT = bcd_load(T_SHORT);
    localparam bcd_t LOAD_PED   = bcd_load(T_PED);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic [SYNC_WIDTH-1:0] raw_bits;
    logic [SYNC_WIDTH-1:0] sync_bits;
    logic                  car_s;
    logic                  ped_s;
    logic                  night_s;

    assign raw_bits[SYNC_CAR]   = car_async;
    assign raw_bits[SYNC_PED]   = ped_async;
    assign raw_bits[SYNC_NIGHT] = night_async;

    param_traffic_light_controller_input_synchroniser #(
        .WIDTH  (SYNC_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_input_synchroniser (
        .clk        (clk),
        .reset      (reset),
        .async_bits (raw_bits),
        .sync_bits  (sync_bits)
    );

    assign car_s   = sync_bits[SYNC_CAR];
    assign ped_s   = sync_bits[SYNC_PED];
    assign night_s = sync_bits[SYNC_NIGHT];

    // ------------------------------------------------------------------
    // Seconds prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_reg;
    logic               tick;

    assign tick = (presc_reg == PRESC_LAST);

    // Count 0..CLK_DIV-1 and wrap; tick marks the last count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Controller state, countdown, flash phase and pedestrian latch
    // ------------------------------------------------------------------
    logic [2:0] state_reg;
    logic [2:0] state_next;
    bcd_t       timer_reg;
    bcd_t       timer_next;
    logic       phase_reg;
    logic       phase_next;
    logic       ped_prev_reg;
    logic       ped_pending_reg;
    logic       ped_pending_next;
    logic       ped_rise;
    logic       ped_clear;
    logic       timer_is_one;
    logic       timer_gt_one;

    assign timer_is_one = bcd_is_one(timer_reg);
    assign timer_gt_one = bcd_gt_one(timer_reg);
    assign ped_rise     = ped_s & ~ped_prev_reg;

    // Next-state, countdown and flash-phase decisions, evaluated on ticks only
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        phase_next = phase_reg;
        ped_clear  = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_HG: begin
                    // Night mode pre-empts the highway green at any count
                    if (night_s) begin
                        state_next = ST_FLASH;
                        timer_next = BCD_ZERO;
                    end else if (timer_is_one) begin
                        if (car_s || ped_pending_reg) begin
                            state_next = ST_HY;
                            timer_next = LOAD_SHORT;
                        end
                    end else if (timer_gt_one) begin
                        timer_next = bcd_dec(timer_reg);
                    end
                end
                ST_HY: begin
                    if (timer_is_one) begin
                        if (ped_pending_reg) begin
                            state_next = ST_PED;
                            timer_next = LOAD_PED;
                            ped_clear  = 1'b1;
                        end else begin
                            state_next = ST_SG;
                            timer_next = LOAD_LONG;
                        end
                    end else if (timer_gt_one) begin
                        timer_next = bcd_dec(timer_reg);
                    end
                end
                ST_SG: begin
                    // An empty street ends the street green early
                    if (!car_s || timer_is_one) begin
                        state_next = ST_SY;
                        timer_next = LOAD_SHORT;
                    end else if (timer_gt_one) begin
                        timer_next = bcd_dec(timer_reg);
                    end
                end
                ST_SY: begin
                    if (timer_is_one) begin
                        state_next = ST_HG;
                        timer_next = LOAD_LONG;
                    end else if (timer_gt_one) begin
                        timer_next = bcd_dec(timer_reg);
                    end
                end
                ST_PED: begin
                    if (timer_is_one) begin
                        state_next = car_s ? ST_SG : ST_HG;
                        timer_next = LOAD_LONG;
                    end else if (timer_gt_one) begin
                        timer_next = bcd_dec(timer_reg);
                    end
                end
                ST_FLASH: begin
                    // Leaving night mode discards any stale walk request
                    if (!night_s) begin
                        state_next = ST_HG;
                        timer_next = LOAD_LONG;
                        ped_clear  = 1'b1;
                    end else begin
                        phase_next = ~phase_reg;
                    end
                end
                default: begin
                    state_next = ST_HG;
                    timer_next = LOAD_LONG;
                end
            endcase
        end

        // Each flashing period starts dark
        if (state_next != ST_FLASH) begin
            phase_next = 1'b0;
        end
    end

    // Pedestrian latch: a new press wins over a simultaneous clear
    always_comb begin
        ped_pending_next = ped_pending_reg;
        if (ped_rise) begin
            ped_pending_next = 1'b1;
        end else if (ped_clear) begin
            ped_pending_next = 1'b0;
        end
    end

    // Register the controller state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_HG;
            timer_reg       <= LOAD_LONG;
            phase_reg       <= 1'b0;
            ped_prev_reg    <= 1'b0;
            ped_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            phase_reg       <= phase_next;
            ped_prev_reg    <= ped_s;
            ped_pending_reg <= ped_pending_next;
        end
    end

    // ------------------------------------------------------------------
    // Lamp decode straight from registered state (no extra latency)
    // ------------------------------------------------------------------
    logic [NUM_LAMPS-1:0] lamps;

    // Map each state to its lamp pattern; unknown states show all red
    always_comb begin
        lamps = '0;
        case (state_reg)
            ST_HG: begin
                lamps[LAMP_GREEN_HW] = 1'b1;
                lamps[LAMP_RED_ST]   = 1'b1;
            end
            ST_HY: begin
                lamps[LAMP_YELLOW_HW] = 1'b1;
                lamps[LAMP_RED_ST]    = 1'b1;
            end
            ST_SG: begin
                lamps[LAMP_RED_HW]   = 1'b1;
                lamps[LAMP_GREEN_ST] = 1'b1;
            end
            ST_SY: begin
                lamps[LAMP_RED_HW]    = 1'b1;
                lamps[LAMP_YELLOW_ST] = 1'b1;
            end
            ST_PED: begin
                lamps[LAMP_RED_HW] = 1'b1;
                lamps[LAMP_RED_ST] = 1'b1;
                lamps[LAMP_WALK]   = 1'b1;
            end
            ST_FLASH: begin
                lamps[LAMP_YELLOW_HW] = phase_reg;
                lamps[LAMP_RED_ST]    = phase_reg;
            end
            default: begin
                lamps[LAMP_RED_HW] = 1'b1;
                lamps[LAMP_RED_ST] = 1'b1;
            end
        endcase
    end

    assign red_highway    = lamps[LAMP_RED_HW];
    assign yellow_highway = lamps[LAMP_YELLOW_HW];
    assign green_highway  = lamps[LAMP_GREEN_HW];
    assign red_street     = lamps[LAMP_RED_ST];
    assign yellow_street  = lamps[LAMP_YELLOW_ST];
    assign green_street   = lamps[LAMP_GREEN_ST];
    assign walk           = lamps[LAMP_WALK];
    assign count_tens     = timer_reg.tens;
    assign count_ones     = timer_reg.ones;

endmodule

// File: tb/tb_param_traffic_light_controller.sv
// Bench for the intersection controller. A reference model with integer
// seconds and named phases runs alongside the DUT one clock at a time;
// each scenario task compares the full output vector every cycle and adds
// directed checks on phase lengths and boundary behaviour.
module tb_param_traffic_light_controller;

    localparam int CLK_DIV = 4;
    localparam int T_LONG  = 12;
    localparam int T_SHORT = 3;
    localparam int T_PED   = 5;
    localparam int SS      = 2;

    // {red_hw, yellow_hw, green_hw, red_st, yellow_st, green_st, walk, tens, ones}
    localparam logic [14:0] RESET_VEC = {7'b0011000, 4'd1, 4'd2};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_async = 1'b0;
    logic       ped_async = 1'b0;
    logic       night_async = 1'b0;
    logic       red_highway, yellow_highway, green_highway;
    logic       red_street, yellow_street, green_street;
    logic       walk;
    logic [3:0] count_tens, count_ones;

    int n_vec = 0;
    int n_bad = 0;

    param_traffic_light_controller #(
        .CLK_DIV     (CLK_DIV),
        .T_LONG      (T_LONG),
        .T_SHORT     (T_SHORT),
        .T_PED       (T_PED),
        .SYNC_STAGES (SS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .car_async      (car_async),
        .ped_async      (ped_async),
        .night_async    (night_async),
        .red_highway    (red_highway),
        .yellow_highway (yellow_highway),
        .green_highway  (green_highway),
        .red_street     (red_street),
        .yellow_street  (yellow_street),
        .green_street   (green_street),
        .walk           (walk),
        .count_tens     (count_tens),
        .count_ones     (count_ones)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_HG, M_HY, M_SG, M_SY, M_PED, M_FLASH} mphase_e;

    mphase_e         m_st;
    int              m_secs;
    bit              m_flash_on;
    bit              m_ped_req;
    bit              m_ped_last;
    int              m_cyc;
    logic [SS-1:0]   car_sh, ped_sh, night_sh;

    task automatic model_reset();
        m_st       = M_HG;
        m_secs     = T_LONG;
        m_flash_on = 1'b0;
        m_ped_req  = 1'b0;
        m_ped_last = 1'b0;
        m_cyc      = 0;
        car_sh     = '0;
        ped_sh     = '0;
        night_sh   = '0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit tick, car, ped, night, clr;
        tick  = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
        car   = car_sh[SS-1];
        ped   = ped_sh[SS-1];
        night = night_sh[SS-1];
        clr   = 1'b0;
        if (tick) begin
            case (m_st)
                M_HG: begin
                    if (night) begin m_st = M_FLASH; m_secs = 0; end
                    else if (m_secs == 1) begin
                        if (car || m_ped_req) begin m_st = M_HY; m_secs = T_SHORT; end
                    end else m_secs = m_secs - 1;
                end
                M_HY: begin
                    if (m_secs == 1) begin
                        if (m_ped_req) begin m_st = M_PED; m_secs = T_PED; clr = 1'b1; end
                        else begin m_st = M_SG; m_secs = T_LONG; end
                    end else m_secs = m_secs - 1;
                end
                M_SG: begin
                    if (!car || m_secs == 1) begin m_st = M_SY; m_secs = T_SHORT; end
                    else m_secs = m_secs - 1;
                end
                M_SY: begin
                    if (m_secs == 1) begin m_st = M_HG; m_secs = T_LONG; end
                    else m_secs = m_secs - 1;
                end
                M_PED: begin
                    if (m_secs == 1) begin m_st = car ? M_SG : M_HG; m_secs = T_LONG; end
                    else m_secs = m_secs - 1;
                end
                default: begin
                    if (!night) begin
                        m_st = M_HG; m_secs = T_LONG; m_flash_on = 1'b0; clr = 1'b1;
                    end else m_flash_on = !m_flash_on;
                end
            endcase
        end
        if (ped && !m_ped_last) m_ped_req = 1'b1;
        else if (clr)           m_ped_req = 1'b0;
        m_ped_last = ped;
        car_sh   = {car_sh[SS-2:0], car_async};
        ped_sh   = {ped_sh[SS-2:0], ped_async};
        night_sh = {night_sh[SS-2:0], night_async};
        m_cyc    = m_cyc + 1;
    endtask

    function automatic logic [14:0] model_vec();
        logic [6:0] l;
        case (m_st)
            M_HG:    l = 7'b0011000;
            M_HY:    l = 7'b0101000;
            M_SG:    l = 7'b1000010;
            M_SY:    l = 7'b1000100;
            M_PED:   l = 7'b1001001;
            default: l = {1'b0, m_flash_on, 1'b0, m_flash_on, 3'b000};
        endcase
        return {l, 4'(m_secs / 10), 4'(m_secs % 10)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {red_highway, yellow_highway, green_highway, red_street,
                yellow_street, green_street, walk, count_tens, count_ones};
    endfunction

    // One clock: model follows the edge, caller samples at the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=%h", dut_vec(), RESET_VEC);
        end
        reset = 1'b0;
        for (int i = 0; i < 44; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL idle_countdown cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (dut_vec() !== {7'b0011000, 8'h01}) begin
            n_bad++;
            $display("FAIL idle_after_11_ticks got=%h want=%h", dut_vec(), {7'b0011000, 8'h01});
        end
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL idle_hold cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (dut_vec() !== {7'b0011000, 8'h01}) begin
            n_bad++;
            $display("FAIL idle_hold_end got=%h want=%h", dut_vec(), {7'b0011000, 8'h01});
        end
    endtask

    task automatic test_car_cycle();
        int  hy = 0, sg = 0, sy = 0;
        bit  seen_sy = 1'b0, done = 1'b0;
        logic [7:0] back_count = 8'h00;
        car_async = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL car_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
            if (yellow_highway === 1'b1) hy++;
            if (green_street === 1'b1) sg++;
            if (yellow_street === 1'b1) begin sy++; seen_sy = 1'b1; end
            if (seen_sy && green_highway === 1'b1) begin
                done = 1'b1;
                back_count = {count_tens, count_ones};
            end
        end
        car_async = 1'b0;
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL car_cycle_timeout got=no_return want=return_to_hg");
        end
        n_vec++;
        if (hy != 4 * T_SHORT || sg != 4 * T_LONG || sy != 4 * T_SHORT) begin
            n_bad++;
            $display("FAIL car_cycle_lengths got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     hy, sg, sy, 4 * T_SHORT, 4 * T_LONG, 4 * T_SHORT);
        end
        n_vec++;
        if (back_count !== 8'h12) begin
            n_bad++;
            $display("FAIL car_cycle_reload got=%h want=12", back_count);
        end
    endtask

    task automatic test_early_exit();
        bit  found = 1'b0;
        int  waited = 0;
        logic [7:0] last_sg = 8'h00;
        car_async = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL early_reach cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
            if (green_street === 1'b1 && {count_tens, count_ones} === 8'h09) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL early_timeout got=no_sg_at_9 want=sg_at_9");
        end
        car_async = 1'b0;
        while (green_street === 1'b1 && waited < 10) begin
            last_sg = {count_tens, count_ones};
            cycle();
            waited++;
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL early_exit cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (waited != 4 || last_sg !== 8'h09 || yellow_street !== 1'b1 ||
            {count_tens, count_ones} !== 8'h03) begin
            n_bad++;
            $display("FAIL early_exit_entry got=cyc%0d sg%h ys%b cnt%h%h want=cyc4 sg09 ys1 cnt03",
                     waited, last_sg, yellow_street, count_tens, count_ones);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL early_return cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_pedestrian();
        bit  found = 1'b0, seen_walk = 1'b0, done = 1'b0;
        int  walk_cyc = 0;
        logic [7:0] back_count = 8'h00;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL ped_reach cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
            if (green_highway === 1'b1 && {count_tens, count_ones} === 8'h07) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL ped_timeout got=no_hg_at_7 want=hg_at_7");
        end
        ped_async = 1'b1;
        cycle();
        ped_async = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL ped_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
            if (walk === 1'b1) begin
                seen_walk = 1'b1;
                walk_cyc++;
                n_vec++;
                if ({red_highway, yellow_highway, green_highway,
                     red_street, yellow_street, green_street} !== 6'b100100) begin
                    n_bad++;
                    $display("FAIL ped_all_red got=%b%b%b%b%b%b want=100100",
                             red_highway, yellow_highway, green_highway,
                             red_street, yellow_street, green_street);
                end
            end
            if (seen_walk && green_highway === 1'b1) begin
                done = 1'b1;
                back_count = {count_tens, count_ones};
            end
        end
        n_vec++;
        if (!done || walk_cyc != 4 * T_PED || back_count !== 8'h12) begin
            n_bad++;
            $display("FAIL ped_phase got=done%b walk%0d cnt%h want=done1 walk%0d cnt12",
                     done, walk_cyc, back_count, 4 * T_PED);
        end
        for (int i = 0; i < 60; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL ped_after cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (dut_vec() !== {7'b0011000, 8'h01}) begin
            n_bad++;
            $display("FAIL ped_request_cleared got=%h want=%h", dut_vec(), {7'b0011000, 8'h01});
        end
    endtask

    task automatic test_night();
        int   waited = 0, toggles = 0;
        logic prev_y;
        night_async = 1'b1;
        while (green_highway === 1'b1 && waited < 12) begin
            cycle();
            waited++;
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL night_enter cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (green_highway !== 1'b0 || {count_tens, count_ones} !== 8'h00) begin
            n_bad++;
            $display("FAIL night_entry got=gh%b cnt%h%h want=gh0 cnt00",
                     green_highway, count_tens, count_ones);
        end
        prev_y = yellow_highway;
        for (int i = 0; i < 24; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec() || yellow_highway !== red_street) begin
                n_bad++;
                $display("FAIL night_flash cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
            if (yellow_highway !== prev_y) toggles++;
            prev_y = yellow_highway;
        end
        n_vec++;
        if (toggles != 6) begin
            n_bad++;
            $display("FAIL night_toggle_rate got=%0d want=6", toggles);
        end
        night_async = 1'b0;
        waited = 0;
        while (green_highway !== 1'b1 && waited < 12) begin
            cycle();
            waited++;
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL night_exit cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (dut_vec() !== {7'b0011000, 8'h12}) begin
            n_bad++;
            $display("FAIL night_return got=%h want=%h", dut_vec(), {7'b0011000, 8'h12});
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        car_async = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL areset_reach cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
            if (green_street === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL areset_timeout got=no_sg want=sg");
        end
        #2;
        reset = 1'b1;
        car_async = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL areset_immediate got=%h want=%h", dut_vec(), RESET_VEC);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL areset_resume cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) car_async = ~car_async;
            ped_async = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 399) == 0) night_async = ~night_async;
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            cycle();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        car_async   = 1'b0;
        ped_async   = 1'b0;
        night_async = 1'b0;
    endtask

    initial begin
        test_reset();
        test_car_cycle();
        test_early_exit();
        test_pedestrian();
        test_night();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/param_traffic_light_controller.md
Name: param_traffic_light_controller

Overview:
Next-generation highway/street intersection controller. Phase timings, the seconds prescaler and the sensor synchroniser depth are parameters. It adds a latched pedestrian request with an all-red walk phase and a night flashing mode. It drives six lamp outputs, a walk lamp and a two-digit BCD countdown; 7-segment decoding stays external.

Parameters:
CLK_DIV, 50000000, clock cycles per one-second tick (>=2)
T_LONG, 25, highway-green minimum and street-green maximum, in seconds (2..99)
T_SHORT, 5, yellow duration, in seconds (1..99)
T_PED, 10, all-red walk duration, in seconds (1..99)
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
car_async  in  1  street car sensor, asynchronous
ped_async  in  1  pedestrian button, asynchronous
night_async  in  1  night-mode switch, asynchronous
red_highway / yellow_highway / green_highway  out  1 each  highway lamps
red_street / yellow_street / green_street  out  1 each  street lamps
walk  out  1  pedestrian walk lamp
count_tens  out  4  BCD tens digit of remaining seconds
count_ones  out  4  BCD ones digit of remaining seconds

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. Every flop clears on posedge reset.
- Synchronisers: car_s, ped_s and night_s each pass through SYNC_STAGES flops. Their latency is SYNC_STAGES cycles.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick = 1 for one cycle when count == CLK_DIV-1.
- Timer: a BCD pair, not binary, so no divider is needed.
  - It is loaded with the parameter value of a state on entry to that state.
  - It decrements by 1 on each tick while its value is greater than 1. BCD borrow: ones 0 becomes 9 and tens decrements.
- Transitions are evaluated only on a tick and only when timer == 1. The display therefore shows T..1 and each state lasts T ticks unless it holds.
- ped_pending:
  - Set on a rising edge of ped_s.
  - Cleared in the cycle the controller enters PED.
  - If a set and a clear occur in the same cycle, the set wins (the request is re-armed).
- States:
  - HG (highway green): holds at timer 1 until car_s or ped_pending, then goes to HY. If night_s is high on a tick in HG, it goes to FLASH regardless of the timer.
  - HY (highway yellow, T_SHORT): goes to PED if ped_pending, else to SG.
  - SG (street green, T_LONG): goes to SY at timer 1, or on any tick where car_s == 0. The early exit is allowed at any timer value.
  - SY (street yellow, T_SHORT): goes to HG.
  - PED (T_PED): goes to SG if car_s, else to HG.
  - FLASH: a phase bit toggles on every tick. The timer is held at 00. On a tick with night_s == 0, it goes to HG with timer = T_LONG and ped_pending is cleared.
- Lamps are decoded from the registered state and phase (no added latency):
  - HG: green_highway, red_street.
  - HY: yellow_highway, red_street.
  - SG: red_highway, green_street.
  - SY: red_highway, yellow_street.
  - PED: red_highway, red_street, walk.
  - FLASH: yellow_highway = phase, red_street = phase, all other lamps 0.
- Exactly one highway lamp and one street lamp are lit in every non-FLASH state.
- Reset values:
  - state HG, timer T_LONG, prescaler 0, phase 0, ped_pending 0, synchronisers 0.
  - Outputs: green_highway = 1, red_street = 1, all other lamps 0, walk 0, count = BCD(T_LONG).
- Reset mid-operation returns immediately to the reset values. There is no partial-phase recovery.

Decomposition:
- Shared include traffic_defs.vh holds:
  - the state encodings (HG, HY, SG, SY, PED, FLASH, 3-bit);
  - the lamp bit-position constants;
  - the BCD load function/macro that converts a 0..99 parameter to a tens/ones pair.
- One sub-module, input_synchroniser: parameters WIDTH and STAGES, async active-high reset. It is instantiated once with WIDTH = 3.
- The prescaler, BCD timer and FSM live in the top module.

Test Plan:
All scenarios use CLK_DIV = 4, T_LONG = 12, T_SHORT = 3, T_PED = 5, SYNC_STAGES = 2.
- Reset and idle hold: pulse reset with no inputs -> green_highway = 1, red_street = 1, count 1,2 → 0,1 after 11 ticks, then held at 0,1 in HG indefinitely.
- Car cycle: assert car_async after 20 ticks with it held high -> HY for 3 ticks, SG for 12 ticks (count 12..1), SY for 3 ticks, back to HG reloaded with 12.
- Early street exit: in SG at count 9, drop car_async -> on the first tick after 2 sync cycles, SY is entered with count 3.
- Pedestrian: pulse ped_async for 1 cycle during HG at count 7 (no car) -> at count 1 → HY → PED with walk = 1 and all reds for 5 ticks → HG; ped_pending is 0 afterwards.
- Night mode: assert night_async in HG -> FLASH, with yellow_highway and red_street toggling every 4 clocks and count 0,0. Deassert -> HG with count 12.
- Async reset mid-SG: assert reset between clock edges -> outputs reach reset values before the next clk edge.
